// File: rtl/nibbler_io_pkg.sv
// Shared types and helpers for the Nibbler output-port serial transmitter:
// FSM state encoding, frame geometry and the parity helper.
package nibbler_io_pkg;

    localparam int PORT_W     = 2;
    localparam int FRAME_BITS = 3 + PORT_W + 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Start + port + data + parity + stop for an n-bit data field.
    function automatic int frame_bits(input int n);
        return 3 + PORT_W + n;
    endfunction

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [31:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/nibble_fifo.sv
// Circular-buffer FIFO with a separate occupancy counter; the head entry is
// presented combinationally on dout.
module nibble_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full  = (r_count == DEPTH_C);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A pop on the same edge frees the slot, so a push into a full buffer is legal then.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage has no reset; the counter gates every read, so stale contents are never used.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/nibble_port_tx.sv
// Nibbler output-port serial transmitter: buffers (port, nibble) writes and
// shifts each out as an LSB-first framed word with even parity on tx.
module nibble_port_tx
    import nibbler_io_pkg::*;
#(
    parameter int N            = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [PORT_W-1:0] wr_port,
    input  logic [N-1:0]      wr_data,
    output logic              full,
    output logic              overflow,
    output logic              busy,
    output logic              tx
);

    localparam int ENTRY_W = PORT_W + N;
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int BW      = $clog2(CLKS_PER_BIT);
    localparam int IW      = $clog2(frame_bits(N));

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] ADDR_LAST = IW'(PORT_W - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(ENTRY_W - 1);

    tx_state_t          r_state;
    tx_state_t          w_next_state;
    logic [BW-1:0]      r_baud;
    logic [IW-1:0]      r_bit_idx;
    logic [ENTRY_W-1:0] r_shift;
    logic               r_parity;
    logic               r_tx;
    logic               r_overflow;

    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [CW-1:0]      w_fifo_count;
    logic [ENTRY_W-1:0] w_fifo_dout;
    logic               w_push;
    logic               w_pop;
    logic               w_baud_wrap;
    logic               w_tx_bit;

    assign w_push      = wr_en && (!w_fifo_full || w_pop);
    assign w_baud_wrap = (r_baud == BAUD_LAST);

    // Entries hold {data, port} so one right shift walks port bits then data bits.
    nibble_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({wr_data, wr_port}),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (!w_fifo_empty) w_next_state = ST_START;
            ST_START:  if (w_baud_wrap) w_next_state = ST_ADDR;
            ST_ADDR:   if (w_baud_wrap && r_bit_idx == ADDR_LAST) w_next_state = ST_DATA;
            ST_DATA:   if (w_baud_wrap && r_bit_idx == DATA_LAST) w_next_state = ST_PARITY;
            ST_PARITY: if (w_baud_wrap) w_next_state = ST_STOP;
            ST_STOP: begin
                if (w_baud_wrap) w_next_state = w_fifo_empty ? ST_IDLE : ST_START;
            end
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tx_bit = 1'b1;
        w_pop    = 1'b0;
        case (r_state)
            ST_IDLE:          w_pop    = !w_fifo_empty;
            ST_START:         w_tx_bit = 1'b0;
            ST_ADDR, ST_DATA: w_tx_bit = r_shift[0];
            ST_PARITY:        w_tx_bit = r_parity;
            ST_STOP:          w_pop    = w_baud_wrap && !w_fifo_empty;
            default:          ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_tx <= w_tx_bit;
            if (wr_en && !w_push) r_overflow <= 1'b1;

            if (r_state == ST_IDLE || w_baud_wrap) r_baud <= '0;
            else                                   r_baud <= r_baud + BW'(1);

            if (w_pop) begin
                r_shift   <= w_fifo_dout;
                r_parity  <= even_parity(32'(w_fifo_dout));
                r_bit_idx <= '0;
            end else if (w_baud_wrap && (r_state == ST_ADDR || r_state == ST_DATA)) begin
                r_shift   <= r_shift >> 1;
                r_bit_idx <= r_bit_idx + IW'(1);
            end
        end
    end

    assign tx       = r_tx;
    assign overflow = r_overflow;
    assign full     = w_fifo_full;
    assign busy     = (r_state != ST_IDLE) || (w_fifo_count != '0);

endmodule

// File: tb/tb_nibble_port_tx.sv
// Bench for nibble_port_tx: a bench-side serial receiver decodes tx into frames, which
// are compared with frames built directly from the framing rules for each accepted write.
module tb_nibble_port_tx;

    localparam int N         = 4;
    localparam int DEPTH     = 4;
    localparam int CPB       = 4;
    localparam int NBITS     = 3 + 2 + N;
    localparam int FRAME_CYC = NBITS * CPB;

    logic         clk     = 1'b0;
    logic         reset   = 1'b1;
    logic         wr_en   = 1'b0;
    logic [1:0]   wr_port = 2'd0;
    logic [N-1:0] wr_data = '0;
    logic         full;
    logic         overflow;
    logic         busy;
    logic         tx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [NBITS-1:0] bits;
        bit               stable;
        int               start_cyc;
    } rx_frame_t;

    rx_frame_t              rx_q[$];
    logic                   rx_active = 1'b0;
    int                     rx_n      = 0;
    int                     rx_start  = 0;
    logic [FRAME_CYC-1:0]   rx_samp   = '0;

    nibble_port_tx #(
        .N            (N),
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_port  (wr_port),
        .wr_data  (wr_data),
        .full     (full),
        .overflow (overflow),
        .busy     (busy),
        .tx       (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference frame: start, port LSB first, data LSB first, even parity, stop.
    function automatic logic [NBITS-1:0] exp_frame(input logic [1:0] p, input logic [N-1:0] d);
        logic [NBITS-1:0] f;
        f[0] = 1'b0;
        f[1] = p[0];
        f[2] = p[1];
        for (int i = 0; i < N; i++) f[3+i] = d[i];
        f[3+N] = ^{p, d};
        f[4+N] = 1'b1;
        return f;
    endfunction

    function automatic rx_frame_t decode(input logic [FRAME_CYC-1:0] s, input int st);
        rx_frame_t f;
        f.stable    = 1'b1;
        f.start_cyc = st;
        for (int b = 0; b < NBITS; b++) begin
            f.bits[b] = s[b*CPB];
            for (int j = 1; j < CPB; j++)
                if (s[b*CPB+j] !== s[b*CPB]) f.stable = 1'b0;
        end
        return f;
    endfunction

    // Receiver: samples tx once per cycle on the falling edge, one frame per start bit.
    always @(negedge clk) begin
        if (reset) begin
            rx_active <= 1'b0;
        end else if (rx_active) begin
            rx_samp[rx_n] <= tx;
            rx_n          <= rx_n + 1;
            if (rx_n == FRAME_CYC - 1) begin
                rx_q.push_back(decode({tx, rx_samp[FRAME_CYC-2:0]}, rx_start));
                rx_active <= 1'b0;
            end
        end else if (tx === 1'b0) begin
            rx_active  <= 1'b1;
            rx_n       <= 1;
            rx_samp[0] <= 1'b0;
            rx_start   <= cyc;
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drive_write(input logic [1:0] p, input logic [N-1:0] d);
        wr_en   = 1'b1;
        wr_port = p;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (rx_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (rx_q.size() < n) begin
            errors++;
            $display("FAIL frame_timeout: got %0d frames expected %0d", rx_q.size(), n);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy got %b expected 0", busy);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_rx_start(output int s);
        int t = 0;
        while (rx_active !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (rx_active !== 1'b1) begin
            errors++;
            $display("FAIL start_timeout: rx_active got %b expected 1", rx_active);
        end
        s = rx_start;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rx_q.delete();
    endtask

    task automatic test_reset();
        bit went_low = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL reset_overflow: got %b expected 0", overflow);
        end
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1) went_low = 1'b1;
        end
        checks++;
        if (went_low) begin errors++; $display("FAIL reset_idle_tx: got low expected steady 1"); end
    endtask

    task automatic test_single();
        int k;
        rx_q.delete();
        @(negedge clk);
        k = cyc + 1;
        drive_write(2'd1, 4'd3);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_write: got %b expected 1", busy); end
        wait_until(k + 1);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_pre: got %b expected 1", tx); end
        wait_until(k + 2);
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL single_latency: got %b expected 0", tx); end
        wait_until(k + 36);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_stop: got %b expected 1", busy); end
        wait_until(k + 38);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
        wait_frames(1, 20);
        if (rx_q.size() >= 1) begin
            checks++;
            if (rx_q[0].bits !== 9'b110011010) begin
                errors++; $display("FAIL single_seq: got %b expected %b", rx_q[0].bits, 9'b110011010);
            end
            checks++;
            if (rx_q[0].bits !== exp_frame(2'd1, 4'd3)) begin
                errors++;
                $display("FAIL single_model: got %b expected %b", rx_q[0].bits, exp_frame(2'd1, 4'd3));
            end
            checks++;
            if (rx_q[0].stable !== 1'b1) begin
                errors++; $display("FAIL single_bit_width: got unstable expected 4-cycle bits");
            end
            checks++;
            if (rx_q[0].start_cyc != k + 2) begin
                errors++; $display("FAIL single_start: got %0d expected %0d", rx_q[0].start_cyc, k + 2);
            end
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [1:0]   ep[$];
        logic [N-1:0] ed[$];
        rx_q.delete();
        ep = '{2'd0, 2'd2};
        ed = '{4'd2, 4'd4};
        @(negedge clk);
        for (int i = 0; i < 2; i++) drive_write(ep[i], ed[i]);
        wait_frames(2, 2 * FRAME_CYC + 20);
        for (int i = 0; i < rx_q.size() && i < 2; i++) begin
            checks++;
            if (rx_q[i].bits !== exp_frame(ep[i], ed[i]) || rx_q[i].stable !== 1'b1) begin
                errors++;
                $display("FAIL b2b_frame%0d: got %b expected %b", i, rx_q[i].bits, exp_frame(ep[i], ed[i]));
            end
        end
        if (rx_q.size() >= 2) begin
            checks++;
            if (rx_q[1].start_cyc - rx_q[0].start_cyc != FRAME_CYC) begin
                errors++;
                $display("FAIL b2b_gap: got %0d expected %0d",
                         rx_q[1].start_cyc - rx_q[0].start_cyc, FRAME_CYC);
            end
        end
        wait_idle();
    endtask

    task automatic test_random_bursts();
        logic [1:0]   ep[$];
        logic [N-1:0] ed[$];
        int           len;
        for (int r = 0; r < 4; r++) begin
            ep.delete();
            ed.delete();
            rx_q.delete();
            len = $urandom_range(1, 5);
            @(negedge clk);
            for (int i = 0; i < len; i++) begin
                ep.push_back(2'($urandom_range(0, 3)));
                ed.push_back(4'($urandom_range(0, 15)));
                drive_write(ep[i], ed[i]);
            end
            wait_frames(len, len * FRAME_CYC + 20);
            for (int i = 0; i < rx_q.size() && i < len; i++) begin
                checks++;
                if (rx_q[i].bits !== exp_frame(ep[i], ed[i]) || rx_q[i].stable !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_r%0d_f%0d: got %b expected %b", r, i, rx_q[i].bits,
                             exp_frame(ep[i], ed[i]));
                end
                if (i > 0) begin
                    checks++;
                    if (rx_q[i].start_cyc - rx_q[i-1].start_cyc != FRAME_CYC) begin
                        errors++;
                        $display("FAIL rand_r%0d_gap%0d: got %0d expected %0d", r, i,
                                 rx_q[i].start_cyc - rx_q[i-1].start_cyc, FRAME_CYC);
                    end
                end
            end
            checks++;
            if (overflow !== 1'b0) begin
                errors++; $display("FAIL rand_r%0d_overflow: got %b expected 0", r, overflow);
            end
            wait_idle();
        end
    endtask

    task automatic test_overflow();
        logic [1:0]   ep[$];
        logic [N-1:0] ed[$];
        logic [1:0]   p;
        logic [N-1:0] d;
        rx_q.delete();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            p = 2'($urandom_range(0, 3));
            d = 4'($urandom_range(0, 15));
            if (i < 5) begin
                ep.push_back(p);
                ed.push_back(d);
            end
            drive_write(p, d);
            if (i == 3) begin
                checks++;
                if (full !== 1'b0) begin errors++; $display("FAIL ovf_full_w4: got %b expected 0", full); end
            end
            if (i == 4) begin
                checks++;
                if (full !== 1'b1) begin errors++; $display("FAIL ovf_full_w5: got %b expected 1", full); end
                checks++;
                if (overflow !== 1'b0) begin
                    errors++; $display("FAIL ovf_early: got %b expected 0", overflow);
                end
            end
            if (i == 5) begin
                checks++;
                if (overflow !== 1'b1) begin
                    errors++; $display("FAIL ovf_set: got %b expected 1", overflow);
                end
            end
        end
        wait_frames(5, 5 * FRAME_CYC + 40);
        repeat (60) @(negedge clk);
        checks++;
        if (rx_q.size() != 5) begin
            errors++; $display("FAIL ovf_frame_count: got %0d expected 5", rx_q.size());
        end
        for (int i = 0; i < rx_q.size() && i < 5; i++) begin
            checks++;
            if (rx_q[i].bits !== exp_frame(ep[i], ed[i]) || rx_q[i].stable !== 1'b1) begin
                errors++;
                $display("FAIL ovf_frame%0d: got %b expected %b", i, rx_q[i].bits, exp_frame(ep[i], ed[i]));
            end
        end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", full); end
    endtask

    task automatic test_push_pop_full();
        logic [1:0]   ep[$];
        logic [N-1:0] ed[$];
        int           s;
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            ep.push_back(2'($urandom_range(0, 3)));
            ed.push_back(4'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 5; i++) drive_write(ep[i], ed[i]);
        wait_rx_start(s);
        wait_until(s + 34);
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL pp_full_before: got %b expected 1", full); end
        drive_write(ep[5], ed[5]);
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL pp_full_after: got %b expected 1", full); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow: got %b expected 0", overflow); end
        wait_frames(6, 6 * FRAME_CYC + 40);
        for (int i = 0; i < rx_q.size() && i < 6; i++) begin
            checks++;
            if (rx_q[i].bits !== exp_frame(ep[i], ed[i]) || rx_q[i].stable !== 1'b1) begin
                errors++;
                $display("FAIL pp_frame%0d: got %b expected %b", i, rx_q[i].bits, exp_frame(ep[i], ed[i]));
            end
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_frame();
        int           s;
        bit           went_low = 1'b0;
        logic [1:0]   p;
        logic [N-1:0] d;
        apply_reset();
        @(negedge clk);
        drive_write(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)) & 4'b1101);
        drive_write(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        drive_write(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        wait_rx_start(s);
        wait_until(s + 16);
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL mid_data_bit: got %b expected 0", tx); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL mid_tx: got %b expected 1", tx); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL mid_full: got %b expected 0", full); end
        @(negedge clk);
        reset = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) went_low = 1'b1;
        end
        checks++;
        if (went_low) begin errors++; $display("FAIL mid_discard: got activity expected idle"); end
        checks++;
        if (rx_q.size() != 0) begin
            errors++; $display("FAIL mid_frames: got %0d expected 0", rx_q.size());
        end
        p = 2'($urandom_range(0, 3));
        d = 4'($urandom_range(0, 15));
        drive_write(p, d);
        wait_frames(1, FRAME_CYC + 20);
        if (rx_q.size() >= 1) begin
            checks++;
            if (rx_q[0].bits !== exp_frame(p, d) || rx_q[0].stable !== 1'b1) begin
                errors++;
                $display("FAIL mid_new_frame: got %b expected %b", rx_q[0].bits, exp_frame(p, d));
            end
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random_bursts();
        test_overflow();
        test_push_pop_full();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
